hyperbus_w_serializer: RTL

//  Next-generation AXI W-channel to HyperBus PHY write-data serializer, between AXI front-end and PHY CDC FIFO.

---
 rtl/hyperbus_w_serializer.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hyperbus_w_serializer.sv
// AXI W-channel to HyperBus PHY write-data serializer: buffers W beats, then splits or packs them into PHY words.
// Optional burst-length checking is compiled in when HYPERBUS_WSER_LEN_CHECK_EN is defined.
module hyperbus_w_serializer #(
  parameter int AxiDataWidth = 64,
  parameter int NumPhys      = 2,
  parameter int LenWidth     = 8,
  parameter int BufDepth     = 2,
  parameter int AddrWidth    = $clog2(AxiDataWidth/8)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [AddrWidth-1:0]      cmd_addr_i,
  input  logic [2:0]                cmd_size_i,
  input  logic [LenWidth-1:0]       cmd_len_i,
  input  logic                      cmd_fixed_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [AxiDataWidth-1:0]   w_data_i,
  input  logic [AxiDataWidth/8-1:0] w_strb_i,
  input  logic                      w_last_i,
  output logic                      phy_valid_o,
  input  logic                      phy_ready_i,
  output logic [16*NumPhys-1:0]     phy_data_o,
  output logic [2*NumPhys-1:0]      phy_strb_o,
  output logic                      phy_last_o,
  output logic                      busy_o,
  output logic                      err_o
);
  localparam int NumBytes = AxiDataWidth/8;
  localparam int PhyBytes = 2*NumPhys;
  localparam int PhyWidth = 8*PhyBytes;
  localparam int PbLog    = $clog2(PhyBytes);
  localparam int PtrWidth = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam int CntWidth = $clog2(BufDepth+1);
  localparam logic [AddrWidth-1:0] WordTop = AddrWidth'(PhyBytes-1);

  function automatic logic [PhyBytes-1:0] word_lanes(input logic [AddrWidth-1:0] word,
                                                     input logic [AddrWidth-1:0] lo,
                                                     input logic [AddrWidth-1:0] hi);
    logic [AddrWidth-1:0] lane;
    for (int l = 0; l < PhyBytes; l++) begin
      lane = AddrWidth'(int'(word) * PhyBytes + l);
      word_lanes[l] = (lane >= lo) && (lane <= hi);
    end
  endfunction

  function automatic logic [PhyWidth-1:0] keep_bytes(input logic [PhyWidth-1:0] data,
                                                     input logic [PhyBytes-1:0] lanes);
    for (int l = 0; l < PhyBytes; l++) begin
      keep_bytes[8*l +: 8] = lanes[l] ? data[8*l +: 8] : 8'h00;
    end
  endfunction

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
    next_ptr = (ptr == PtrWidth'(BufDepth-1)) ? PtrWidth'(0) : ptr + PtrWidth'(1);
  endfunction

  logic                    active_r, cmd_ready_r, fixed_r;
  logic [AddrWidth-1:0]    addr_r;
  logic [2:0]              size_r;
  logic [AxiDataWidth-1:0] buf_data_r [BufDepth];
  logic [NumBytes-1:0]     buf_strb_r [BufDepth];
  logic [AddrWidth-1:0]    buf_lo_r   [BufDepth];
  logic [AddrWidth-1:0]    buf_hi_r   [BufDepth];
  logic [BufDepth-1:0]     buf_last_r, buf_narrow_r, buf_fixed_r;
  logic [PtrWidth-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CntWidth-1:0]     count_r;
  logic                    started_r, stage_vld_r;
  logic [AddrWidth-1:0]    cur_w_r;
  logic [PhyWidth-1:0]     stage_data_r;
  logic [PhyBytes-1:0]     stage_strb_r;

  logic                    cmd_fire_s, w_fire_s, pop_s, stage_load_s, beat_last_s, narrow_s;
  logic [AddrWidth:0]      bytes_s;
  logic [AddrWidth-1:0]    align_s, hi_s, next_addr_s;
  logic [NumBytes-1:0]     lane_mask_s;
  logic [AxiDataWidth-1:0] head_data_s;
  logic [NumBytes-1:0]     head_strb_s;
  logic [AddrWidth-1:0]    head_lo_s, head_hi_s, head_lo_w_s, head_hi_w_s, cur_w_s;
  logic [PhyWidth-1:0]     word_data_s, masked_data_s, merged_data_s;
  logic [PhyBytes-1:0]     word_strb_s, word_lane_s, merged_strb_s;
  logic                    phy_valid_s, phy_last_s;
  logic [PhyWidth-1:0]     phy_data_s;
  logic [PhyBytes-1:0]     phy_strb_s;

`ifdef HYPERBUS_WSER_LEN_CHECK_EN
  logic [LenWidth-1:0]     len_r, beat_cnt_r;
  logic                    err_r, len_err_s;
`else
  logic                    unused_len_s;
  assign unused_len_s = ^cmd_len_i;
`endif

  assign cmd_fire_s = cmd_valid_i & cmd_ready_r;
  assign w_ready_o  = active_r & ((count_r != CntWidth'(BufDepth)) | pop_s);
  assign w_fire_s   = w_valid_i & w_ready_o;

  // Per-beat lane window, next address and effective last flag.
  always_comb begin
    bytes_s     = (AddrWidth+1)'(1) << size_r;
    align_s     = addr_r & ~(bytes_s[AddrWidth-1:0] - AddrWidth'(1));
    hi_s        = AddrWidth'({1'b0, align_s} + bytes_s - (AddrWidth+1)'(1));
    next_addr_s = AddrWidth'({1'b0, align_s} + bytes_s);
    narrow_s    = bytes_s < (AddrWidth+1)'(PhyBytes);
    lane_mask_s = '0;
    for (int i = 0; i < NumBytes; i++) begin
      lane_mask_s[i] = (AddrWidth'(i) >= addr_r) && (AddrWidth'(i) <= hi_s);
    end
`ifdef HYPERBUS_WSER_LEN_CHECK_EN
    beat_last_s = w_last_i | (beat_cnt_r == len_r);
    len_err_s   = w_last_i ^ (beat_cnt_r == len_r);
`else
    beat_last_s = w_last_i;
`endif
  end

  // Command tracking: latch the burst and advance the lane pointer per accepted beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_r    <= 1'b0;
      cmd_ready_r <= 1'b0;
      addr_r      <= '0;
      size_r      <= 3'd0;
      fixed_r     <= 1'b0;
`ifdef HYPERBUS_WSER_LEN_CHECK_EN
      len_r       <= '0;
      beat_cnt_r  <= '0;
      err_r       <= 1'b0;
`endif
    end else if (cmd_fire_s) begin
      active_r    <= 1'b1;
      cmd_ready_r <= 1'b0;
      addr_r      <= cmd_addr_i;
      size_r      <= cmd_size_i;
      fixed_r     <= cmd_fixed_i;
`ifdef HYPERBUS_WSER_LEN_CHECK_EN
      len_r       <= cmd_len_i;
      beat_cnt_r  <= '0;
      err_r       <= 1'b0;
`endif
    end else if (w_fire_s) begin
      addr_r      <= fixed_r ? addr_r : next_addr_s;
      active_r    <= ~beat_last_s;
      cmd_ready_r <= beat_last_s;
`ifdef HYPERBUS_WSER_LEN_CHECK_EN
      beat_cnt_r  <= beat_cnt_r + LenWidth'(1);
      err_r       <= err_r | len_err_s;
`endif
    end else begin
      cmd_ready_r <= ~active_r;
    end
  end

  // Beat buffer: circular FIFO, push and pop may coincide even when full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BufDepth; i++) begin
        buf_data_r[i] <= '0;
        buf_strb_r[i] <= '0;
        buf_lo_r[i]   <= '0;
        buf_hi_r[i]   <= '0;
      end
      buf_last_r   <= '0;
      buf_narrow_r <= '0;
      buf_fixed_r  <= '0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
    end else begin
      if (w_fire_s) begin
        buf_data_r[wr_ptr_r]   <= w_data_i;
        buf_strb_r[wr_ptr_r]   <= w_strb_i & lane_mask_s;
        buf_lo_r[wr_ptr_r]     <= addr_r;
        buf_hi_r[wr_ptr_r]     <= hi_s;
        buf_last_r[wr_ptr_r]   <= beat_last_s;
        buf_narrow_r[wr_ptr_r] <= narrow_s;
        buf_fixed_r[wr_ptr_r]  <= fixed_r;
        wr_ptr_r               <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({w_fire_s, pop_s})
        2'b10:   count_r <= count_r + CntWidth'(1);
        2'b01:   count_r <= count_r - CntWidth'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Output word selection: split wide beats, merge narrow INCR beats through staging.
  always_comb begin
    head_data_s   = buf_data_r[rd_ptr_r];
    head_strb_s   = buf_strb_r[rd_ptr_r];
    head_lo_s     = buf_lo_r[rd_ptr_r];
    head_hi_s     = buf_hi_r[rd_ptr_r];
    head_lo_w_s   = head_lo_s >> PbLog;
    head_hi_w_s   = head_hi_s >> PbLog;
    cur_w_s       = started_r ? cur_w_r : head_lo_w_s;
    word_data_s   = PhyWidth'(head_data_s >> (cur_w_s * PhyWidth));
    word_strb_s   = PhyBytes'(head_strb_s >> (cur_w_s * PhyBytes));
    word_lane_s   = word_lanes(cur_w_s, head_lo_s, head_hi_s);
    masked_data_s = keep_bytes(word_data_s, word_lane_s);
    merged_data_s = stage_data_r | masked_data_s;
    merged_strb_s = stage_strb_r | (word_strb_s & word_lane_s);
    phy_valid_s   = 1'b0;
    phy_data_s    = '0;
    phy_strb_s    = '0;
    phy_last_s    = 1'b0;
    pop_s         = 1'b0;
    stage_load_s  = 1'b0;
    if (count_r != CntWidth'(0)) begin
      if (!buf_narrow_r[rd_ptr_r]) begin
        phy_valid_s = 1'b1;
        phy_data_s  = word_data_s;
        phy_strb_s  = word_strb_s;
        phy_last_s  = buf_last_r[rd_ptr_r] & (cur_w_s == head_hi_w_s);
        pop_s       = phy_ready_i & (cur_w_s == head_hi_w_s);
      end else if (buf_fixed_r[rd_ptr_r]) begin
        phy_valid_s = 1'b1;
        phy_data_s  = masked_data_s;
        phy_strb_s  = word_strb_s & word_lane_s;
        phy_last_s  = buf_last_r[rd_ptr_r];
        pop_s       = phy_ready_i;
      end else if (((head_hi_s & WordTop) == WordTop) || buf_last_r[rd_ptr_r]) begin
        phy_valid_s = 1'b1;
        phy_data_s  = merged_data_s;
        phy_strb_s  = merged_strb_s;
        phy_last_s  = buf_last_r[rd_ptr_r];
        pop_s       = phy_ready_i;
      end else begin
        pop_s        = 1'b1;
        stage_load_s = 1'b1;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // Word cursor within the head beat and the narrow-beat staging word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      started_r    <= 1'b0;
      cur_w_r      <= '0;
      stage_vld_r  <= 1'b0;
      stage_data_r <= '0;
      stage_strb_r <= '0;
    end else begin
      if (pop_s) begin
        started_r <= 1'b0;
        cur_w_r   <= '0;
      end else if (phy_valid_s && phy_ready_i) begin
        started_r <= 1'b1;
        cur_w_r   <= cur_w_s + AddrWidth'(1);
      end
      if (stage_load_s) begin
        stage_vld_r  <= 1'b1;
        stage_data_r <= merged_data_s;
        stage_strb_r <= merged_strb_s;
      end else if (pop_s) begin
        stage_vld_r  <= 1'b0;
        stage_data_r <= '0;
        stage_strb_r <= '0;
      end
    end
  end

  assign cmd_ready_o = cmd_ready_r;
  assign phy_valid_o = phy_valid_s;
  assign phy_data_o  = phy_data_s;
  assign phy_strb_o  = phy_strb_s;
  assign phy_last_o  = phy_last_s;
  assign busy_o      = active_r | (count_r != CntWidth'(0)) | stage_vld_r;
`ifdef HYPERBUS_WSER_LEN_CHECK_EN
  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

endmodule
